data_mem_unit: RTL

//  Data-memory load/store unit for the RISC-V core. Sits directly upstream of the writeback

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/load_align.sv | 39 +++
 rtl/data_mem_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory path: funct3 codes, FSM encodings and
// the latched request record.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Stores only exist for B/H/W and must be naturally aligned.
    function automatic logic store_ok(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            F3_B:    store_ok = 1'b1;
            F3_H:    store_ok = ~o[0];
            F3_W:    store_ok = (o == 2'b00);
            default: store_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a memory word and extends it; flags
// misaligned offsets and funct3 codes that are not loads.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        bad
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = '0;
        bad  = 1'b0;
        case (funct3)
            F3_B:  data = {{24{b[7]}}, b};
            F3_BU: data = {24'b0, b};
            F3_H:  if (offset[0]) bad = 1'b1; else data = {{16{h[15]}}, h};
            F3_HU: if (offset[0]) bad = 1'b1; else data = {16'b0, h};
            F3_W:  if (offset != 2'b00) bad = 1'b1; else data = word;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store unit over a single-port word array: IDLE -> ACCESS -> RESP, one
// request per three cycles, byte-lane stores and extended loads.
module data_mem_unit
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        rsp_valid,
    output logic [31:0] ReadData,
    output logic        err
);

    state_t      state;
    mem_req_t    rq;
    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      ld_data;
    logic             ld_bad;
    logic             st_ok;
    logic [3:0]       be;
    logic [31:0]      st_data;
    logic             unused_addr_hi;

    assign idx            = rq.addr[IDX_W+1:2];
    assign off            = rq.addr[1:0];
    assign unused_addr_hi = ^rq.addr[31:IDX_W+2];
    assign req_ready      = (state == ST_IDLE);
    assign st_ok          = store_ok(rq.f3, off);

    // Store data is replicated across lanes so the enables alone pick the target.
    always_comb begin
        be      = 4'b0000;
        st_data = {4{rq.wdata[7:0]}};
        case (rq.f3)
            F3_B: be = 4'b0001 << off;
            F3_H: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rq.wdata[15:0]}};
            end
            F3_W: begin
                be      = 4'b1111;
                st_data = rq.wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    load_align u_align (
        .word   (mem[idx]),
        .offset (off),
        .funct3 (rq.f3),
        .data   (ld_data),
        .bad    (ld_bad)
    );

    // An async reset in ACCESS drops state to IDLE before the edge, cancelling the write.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && rq.we && st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rq        <= '0;
            rsp_valid <= 1'b0;
            ReadData  <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rq    <= '{we: MemWrite, f3: funct3, addr: Addr, wdata: WriteData};
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    if (rq.we) begin
                        err      <= ~st_ok;
                        ReadData <= '0;
                    end else begin
                        err      <= ld_bad;
                        ReadData <= ld_data;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
